// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types and constants for the fetch/mem-stage memory bus arbiter.
package mem_bus_arbiter_pkg;

    localparam logic MEMREQ_READ  = 1'b0;
    localparam logic MEMREQ_WRITE = 1'b1;

    typedef logic [1:0] arb_state_t;
    localparam arb_state_t ARB_IDLE   = 2'd0;
    localparam arb_state_t ARB_BUSY   = 2'd1;
    localparam arb_state_t ARB_LOCKED = 2'd2;

    typedef enum logic {
        PORT_FETCH = 1'b0,
        PORT_MEM   = 1'b1
    } port_id_e;

    typedef struct packed {
        logic        mode;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic        lock;
    } mem_req_t;

endpackage

// File: rtl/mem_req_slot.sv
// One pending memory request: captured on a request pulse, dropped when granted.
module mem_req_slot
    import mem_bus_arbiter_pkg::*;
(
    input  logic        clk,
    input  logic        rstn,
    input  logic        capture_i,
    input  logic        clear_i,
    input  logic        mode_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    input  logic [3:0]  wstrb_i,
    input  logic        lock_i,
    output logic        valid_o,
    output logic        mode_o,
    output logic [31:0] addr_o,
    output logic [31:0] wdata_o,
    output logic [3:0]  wstrb_o,
    output logic        lock_o
);

    logic     valid_q, valid_d;
    mem_req_t req_q, req_d;

    // A grant in the same cycle as a pulse into an empty slot consumes the
    // pulse directly, so clear takes priority; pulses into a full slot drop.
    always_comb begin
        valid_d = valid_q;
        req_d   = req_q;
        if (clear_i) begin
            valid_d = 1'b0;
        end else if (capture_i && !valid_q) begin
            valid_d = 1'b1;
            req_d   = '{mode: mode_i, addr: addr_i, wdata: wdata_i,
                        wstrb: wstrb_i, lock: lock_i};
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            valid_q <= 1'b0;
            req_q   <= '0;
        end else begin
            valid_q <= valid_d;
            req_q   <= req_d;
        end
    end

    assign valid_o = valid_q;
    assign mode_o  = req_q.mode;
    assign addr_o  = req_q.addr;
    assign wdata_o = req_q.wdata;
    assign wstrb_o = req_q.wstrb;
    assign lock_o  = req_q.lock;

endmodule

// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter sharing one memory bus between fetch and the mem stage,
// with a mem-side lock that keeps the bus across an AMO read/write pair.
module mem_bus_arbiter
    import mem_bus_arbiter_pkg::*;
(
    input  logic        clk,
    input  logic        rstn,
    input  logic        f_request_enable_i,
    input  logic        f_mode_i,
    input  logic [31:0] f_addr_i,
    input  logic [31:0] f_wdata_i,
    input  logic [3:0]  f_wstrb_i,
    output logic        f_response_enable_o,
    output logic [31:0] f_data_o,
    input  logic        m_request_enable_i,
    input  logic        m_mode_i,
    input  logic [31:0] m_addr_i,
    input  logic [31:0] m_wdata_i,
    input  logic [3:0]  m_wstrb_i,
    input  logic        m_lock_i,
    output logic        m_response_enable_o,
    output logic [31:0] m_data_o,
    output logic        request_enable_o,
    output logic        mode_o,
    output logic [31:0] addr_o,
    output logic [31:0] wdata_o,
    output logic [3:0]  wstrb_o,
    input  logic        response_enable_i,
    input  logic [31:0] data_i
);

    // Index 0 is fetch, index 1 is mem, matching port_id_e.
    logic [1:0]  pulse;
    mem_req_t    in_req   [2];
    mem_req_t    eff_req  [2];
    logic [1:0]  slot_valid;
    logic        slot_mode  [2];
    logic [31:0] slot_addr  [2];
    logic [31:0] slot_wdata [2];
    logic [3:0]  slot_wstrb [2];
    logic        slot_lock  [2];
    logic [1:0]  cand;
    logic [1:0]  grant;

    assign pulse     = {m_request_enable_i, f_request_enable_i};
    assign in_req[0] = '{mode: f_mode_i, addr: f_addr_i, wdata: f_wdata_i,
                         wstrb: f_wstrb_i, lock: 1'b0};
    assign in_req[1] = '{mode: m_mode_i, addr: m_addr_i, wdata: m_wdata_i,
                         wstrb: m_wstrb_i, lock: m_lock_i};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_port
            mem_req_slot u_slot (
                .clk       (clk),
                .rstn      (rstn),
                .capture_i (pulse[gi]),
                .clear_i   (grant[gi]),
                .mode_i    (in_req[gi].mode),
                .addr_i    (in_req[gi].addr),
                .wdata_i   (in_req[gi].wdata),
                .wstrb_i   (in_req[gi].wstrb),
                .lock_i    (in_req[gi].lock),
                .valid_o   (slot_valid[gi]),
                .mode_o    (slot_mode[gi]),
                .addr_o    (slot_addr[gi]),
                .wdata_o   (slot_wdata[gi]),
                .wstrb_o   (slot_wstrb[gi]),
                .lock_o    (slot_lock[gi])
            );

            assign cand[gi]    = slot_valid[gi] | pulse[gi];
            assign eff_req[gi] = slot_valid[gi]
                ? '{mode: slot_mode[gi], addr: slot_addr[gi], wdata: slot_wdata[gi],
                    wstrb: slot_wstrb[gi], lock: slot_lock[gi]}
                : in_req[gi];
        end
    endgenerate

    arb_state_t  state_q, state_d;
    port_id_e    owner_q, owner_d;
    port_id_e    last_grant_q, last_grant_d;
    logic        lock_q, lock_d;
    logic        req_en_q, req_en_d;
    mem_req_t    bus_q, bus_d;
    logic        f_resp_q, f_resp_d;
    logic        m_resp_q, m_resp_d;
    logic [31:0] f_data_q, f_data_d;
    logic [31:0] m_data_q, m_data_d;
    port_id_e    gnt_port;
    mem_req_t    gnt_req;

    always_comb begin
        grant = 2'b00;
        case (state_q)
            ARB_IDLE: begin
                if (cand[1] && (!cand[0] || last_grant_q == PORT_FETCH))
                    grant[1] = 1'b1;
                else if (cand[0])
                    grant[0] = 1'b1;
            end
            ARB_LOCKED: grant[1] = cand[1];
            default:    grant    = 2'b00;
        endcase
    end

    assign gnt_port = grant[1] ? PORT_MEM : PORT_FETCH;
    assign gnt_req  = eff_req[gnt_port];

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_grant_d = last_grant_q;
        lock_d       = lock_q;
        req_en_d     = 1'b0;
        bus_d        = bus_q;
        f_resp_d     = 1'b0;
        m_resp_d     = 1'b0;
        f_data_d     = f_data_q;
        m_data_d     = m_data_q;
        if (grant != 2'b00) begin
            req_en_d     = 1'b1;
            bus_d        = gnt_req;
            owner_d      = gnt_port;
            last_grant_d = gnt_port;
            lock_d       = gnt_req.lock;
            state_d      = ARB_BUSY;
        end else if (state_q == ARB_BUSY && response_enable_i) begin
            if (owner_q == PORT_MEM) begin
                m_resp_d = 1'b1;
                m_data_d = data_i;
            end else begin
                f_resp_d = 1'b1;
                f_data_d = data_i;
            end
            state_d = (owner_q == PORT_MEM && lock_q) ? ARB_LOCKED : ARB_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q      <= ARB_IDLE;
            owner_q      <= PORT_FETCH;
            last_grant_q <= PORT_FETCH;
            lock_q       <= 1'b0;
            req_en_q     <= 1'b0;
            bus_q        <= '0;
            f_resp_q     <= 1'b0;
            m_resp_q     <= 1'b0;
            f_data_q     <= '0;
            m_data_q     <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
            lock_q       <= lock_d;
            req_en_q     <= req_en_d;
            bus_q        <= bus_d;
            f_resp_q     <= f_resp_d;
            m_resp_q     <= m_resp_d;
            f_data_q     <= f_data_d;
            m_data_q     <= m_data_d;
        end
    end

    assign request_enable_o    = req_en_q;
    assign mode_o              = bus_q.mode;
    assign addr_o              = bus_q.addr;
    assign wdata_o             = bus_q.wdata;
    assign wstrb_o             = bus_q.wstrb;
    assign f_response_enable_o = f_resp_q;
    assign f_data_o            = f_data_q;
    assign m_response_enable_o = m_resp_q;
    assign m_data_o            = m_data_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: hand-computed expectations per step.
module tb_mem_bus_arbiter;

    logic        clk = 1'b0;
    logic        rstn;
    logic        f_req, f_mode, f_resp;
    logic [31:0] f_addr, f_wdata, f_data;
    logic [3:0]  f_wstrb;
    logic        m_req, m_mode, m_lock, m_resp;
    logic [31:0] m_addr, m_wdata, m_data;
    logic [3:0]  m_wstrb;
    logic        req_en, mode, resp_en;
    logic [31:0] addr, wdata, data;
    logic [3:0]  wstrb;

    int pass_cnt  = 0;
    int total_cnt = 0;
    int extra_req = 0;

    always #5 clk = ~clk;

    mem_bus_arbiter dut (
        .clk                 (clk),
        .rstn                (rstn),
        .f_request_enable_i  (f_req),
        .f_mode_i            (f_mode),
        .f_addr_i            (f_addr),
        .f_wdata_i           (f_wdata),
        .f_wstrb_i           (f_wstrb),
        .f_response_enable_o (f_resp),
        .f_data_o            (f_data),
        .m_request_enable_i  (m_req),
        .m_mode_i            (m_mode),
        .m_addr_i            (m_addr),
        .m_wdata_i           (m_wdata),
        .m_wstrb_i           (m_wstrb),
        .m_lock_i            (m_lock),
        .m_response_enable_o (m_resp),
        .m_data_o            (m_data),
        .request_enable_o    (req_en),
        .mode_o              (mode),
        .addr_o              (addr),
        .wdata_o             (wdata),
        .wstrb_o             (wstrb),
        .response_enable_i   (resp_en),
        .data_i              (data)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) begin
            pass_cnt = pass_cnt + 1;
        end else begin
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle_in();
        f_req   = 1'b0;
        m_req   = 1'b0;
        resp_en = 1'b0;
    endtask

    task automatic drive_f(input logic [31:0] a);
        f_req   = 1'b1;
        f_mode  = 1'b0;
        f_addr  = a;
        f_wdata = 32'h0;
        f_wstrb = 4'h0;
    endtask

    task automatic drive_m(input logic md, input logic [31:0] a, input logic [31:0] wd,
                           input logic [3:0] ws, input logic lk);
        m_req   = 1'b1;
        m_mode  = md;
        m_addr  = a;
        m_wdata = wd;
        m_wstrb = ws;
        m_lock  = lk;
    endtask

    // Bus response in the current cycle; returns one cycle later (r+1).
    task automatic respond(input logic [31:0] d);
        resp_en = 1'b1;
        data    = d;
        step();
        resp_en = 1'b0;
    endtask

    initial begin
        logic exp_port [4];
        exp_port = '{1'b1, 1'b0, 1'b1, 1'b0};
        rstn = 1'b0;
        idle_in();
        f_mode = 0; f_addr = 0; f_wdata = 0; f_wstrb = 0;
        m_mode = 0; m_addr = 0; m_wdata = 0; m_wstrb = 0; m_lock = 0;
        data = 0;
        step();
        step();
        chk("rst_req_en", {31'b0, req_en}, 32'd0);
        chk("rst_f_resp", {31'b0, f_resp}, 32'd0);
        chk("rst_m_resp", {31'b0, m_resp}, 32'd0);
        chk("rst_addr", addr, 32'h0);
        chk("rst_f_data", f_data, 32'h0);
        chk("rst_m_data", m_data, 32'h0);
        rstn = 1'b1;
        step();

        // Single fetch read
        drive_f(32'h0000_1000);
        step();
        idle_in();
        chk("t1_req_en", {31'b0, req_en}, 32'd1);
        chk("t1_addr", addr, 32'h0000_1000);
        chk("t1_mode", {31'b0, mode}, 32'd0);
        step();
        chk("t1_req_pulse", {31'b0, req_en}, 32'd0);
        step();
        step();
        respond(32'hDEAD_BEEF);
        chk("t1_f_resp", {31'b0, f_resp}, 32'd1);
        chk("t1_f_data", f_data, 32'hDEAD_BEEF);
        chk("t1_m_resp", {31'b0, m_resp}, 32'd0);
        step();
        chk("t1_f_resp_pulse", {31'b0, f_resp}, 32'd0);
        chk("t1_f_data_hold", f_data, 32'hDEAD_BEEF);

        // Tie after reset: mem first
        rstn = 1'b0;
        step();
        rstn = 1'b1;
        step();
        drive_f(32'h0000_2000);
        drive_m(1'b1, 32'h0000_3000, 32'hAAAA_5555, 4'b0011, 1'b0);
        step();
        idle_in();
        chk("t2_req_en", {31'b0, req_en}, 32'd1);
        chk("t2_addr_m", addr, 32'h0000_3000);
        chk("t2_mode_m", {31'b0, mode}, 32'd1);
        chk("t2_wdata_m", wdata, 32'hAAAA_5555);
        chk("t2_wstrb_m", {28'b0, wstrb}, 32'h3);
        step();
        respond(32'h1111_1111);
        chk("t2_m_resp", {31'b0, m_resp}, 32'd1);
        chk("t2_m_data", m_data, 32'h1111_1111);
        chk("t2_f_resp0", {31'b0, f_resp}, 32'd0);
        chk("t2_req_gap", {31'b0, req_en}, 32'd0);
        step();
        chk("t2_f_issue", {31'b0, req_en}, 32'd1);
        chk("t2_addr_f", addr, 32'h0000_2000);
        step();
        respond(32'h2222_2222);
        chk("t2_f_resp", {31'b0, f_resp}, 32'd1);
        chk("t2_f_data", f_data, 32'h2222_2222);
        chk("t2_m_resp0", {31'b0, m_resp}, 32'd0);
        chk("t2_m_data_hold", m_data, 32'h1111_1111);

        // Alternating contention: M,F,M,F
        drive_f(32'h0000_4000);
        drive_m(1'b0, 32'h0000_5000, 32'h0, 4'h0, 1'b0);
        step();
        idle_in();
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("t3_req_en_%0d", k), {31'b0, req_en}, 32'd1);
            chk($sformatf("t3_addr_%0d", k), addr,
                exp_port[k] ? 32'h0000_5000 : 32'h0000_4000);
            step();
            respond(32'h100 + 32'(k));
            chk($sformatf("t3_f_resp_%0d", k), {31'b0, f_resp}, {31'b0, !exp_port[k]});
            chk($sformatf("t3_m_resp_%0d", k), {31'b0, m_resp}, {31'b0, exp_port[k]});
            if (k < 3) begin
                if (exp_port[k]) drive_m(1'b0, 32'h0000_5000, 32'h0, 4'h0, 1'b0);
                else             drive_f(32'h0000_4000);
                step();
                idle_in();
            end
        end
        step();
        chk("t3_drain_req", {31'b0, req_en}, 32'd1);
        chk("t3_drain_addr", addr, 32'h0000_5000);
        step();
        respond(32'h0000_0200);
        chk("t3_drain_m_resp", {31'b0, m_resp}, 32'd1);

        // AMO lock holds off a pending fetch
        drive_m(1'b0, 32'h0000_6000, 32'h0, 4'h0, 1'b1);
        step();
        idle_in();
        chk("t4_rd_addr", addr, 32'h0000_6000);
        drive_f(32'h0000_7000);
        step();
        idle_in();
        respond(32'hCAFE_F00D);
        chk("t4_rd_m_resp", {31'b0, m_resp}, 32'd1);
        chk("t4_rd_m_data", m_data, 32'hCAFE_F00D);
        step();
        chk("t4_locked_hold", {31'b0, req_en}, 32'd0);
        drive_m(1'b1, 32'h0000_6004, 32'h1234_5678, 4'b1111, 1'b0);
        step();
        idle_in();
        chk("t4_wr_req", {31'b0, req_en}, 32'd1);
        chk("t4_wr_addr", addr, 32'h0000_6004);
        chk("t4_wr_mode", {31'b0, mode}, 32'd1);
        chk("t4_wr_wdata", wdata, 32'h1234_5678);
        chk("t4_wr_wstrb", {28'b0, wstrb}, 32'hF);
        step();
        respond(32'h0);
        chk("t4_wr_m_resp", {31'b0, m_resp}, 32'd1);
        chk("t4_wr_f_resp0", {31'b0, f_resp}, 32'd0);
        step();
        chk("t4_f_req", {31'b0, req_en}, 32'd1);
        chk("t4_f_addr", addr, 32'h0000_7000);
        step();
        respond(32'h3333_3333);
        chk("t4_f_resp", {31'b0, f_resp}, 32'd1);
        chk("t4_f_data", f_data, 32'h3333_3333);

        // Reset while BUSY drops the in-flight response
        drive_f(32'h0000_8000);
        step();
        idle_in();
        chk("t5_req", {31'b0, req_en}, 32'd1);
        rstn = 1'b0;
        step();
        chk("t5_rst_req_en", {31'b0, req_en}, 32'd0);
        chk("t5_rst_addr", addr, 32'h0);
        chk("t5_rst_f_data", f_data, 32'h0);
        chk("t5_rst_m_data", m_data, 32'h0);
        rstn = 1'b1;
        respond(32'h0000_0099);
        chk("t5_f_resp0", {31'b0, f_resp}, 32'd0);
        chk("t5_m_resp0", {31'b0, m_resp}, 32'd0);
        chk("t5_f_data0", f_data, 32'h0);
        drive_m(1'b0, 32'h0000_9000, 32'h0, 4'h0, 1'b0);
        step();
        idle_in();
        chk("t5_next_req", {31'b0, req_en}, 32'd1);
        chk("t5_next_addr", addr, 32'h0000_9000);
        step();
        respond(32'h4444_4444);
        chk("t5_m_resp", {31'b0, m_resp}, 32'd1);
        chk("t5_m_data", m_data, 32'h4444_4444);

        // Duplicate fetch pulse while its slot is full
        drive_m(1'b0, 32'h0000_B000, 32'h0, 4'h0, 1'b0);
        step();
        idle_in();
        drive_f(32'h0000_A000);
        step();
        drive_f(32'h0000_A004);
        step();
        idle_in();
        respond(32'h0000_0055);
        chk("t6_m_resp", {31'b0, m_resp}, 32'd1);
        step();
        chk("t6_f_req", {31'b0, req_en}, 32'd1);
        chk("t6_f_addr", addr, 32'h0000_A000);
        step();
        respond(32'h0000_0066);
        chk("t6_f_resp", {31'b0, f_resp}, 32'd1);
        chk("t6_f_data", f_data, 32'h0000_0066);
        for (int i = 0; i < 4; i++) begin
            step();
            if (req_en) extra_req++;
        end
        chk("t6_no_dup_req", 32'(extra_req), 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
